simon_round_ctrl: RTL and testbench
===================================

# simon_round_ctrl

Round controller for the Simon Says game. It grows a pseudo-random arrow sequence by one step per round and plays it back to the display. It then compares the player's key presses, taken from the arrow selector's registered `direction`/`clicked` pair, against the stored sequence. It sits between the arrow selector and the arrow display/VGA drawing logic and reports win/fail to the top-level game FSM.

## Interface
- `MAX_LEN`, 16: sequence length that wins the game (2..32).
- `SHOW_CYCLES`, 25_000_000: cycles each arrow is shown.
- `GAP_CYCLES`, 12_500_000: blank cycles after each shown arrow.
- `SEED`, 8'hA5: LFSR reset value (must be nonzero).
- `TIMEOUT_CYCLES`, 250_000_000: listen timeout (used only with the macro).
- `clock`, in, 1: system clock.
- `resetn`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: begin a new game (level sampled each cycle).
- `direction_in`, in, 2: player arrow code (00 up, 01 right, 10 down, 11 left).
- `clicked_in`, in, 1: high while exactly one arrow key is held.
- `arrow_out`, out, 2: arrow code to display.
- `arrow_valid`, out, 1: display `arrow_out` this cycle.
- `round_len`, out, $clog2(MAX_LEN+1): current sequence length.
- `listening`, out, 1: high while awaiting player input.
- `win`, out, 1: sticky; the game is won.
- `fail`, out, 1: sticky; the game is lost.

## Operation
- States: IDLE, EXTEND, SHOW, GAP, LISTEN, WIN, FAIL.
- 8-bit Fibonacci LFSR (taps 8,6,5,4) advances every cycle in every state, starting from `SEED`.
- IDLE, WIN, FAIL: `start`=1 → EXTEND next cycle. This clears `round_len`, `win` and `fail`, and clears the pattern index `idx`.
- `start` is ignored in all other states.
- EXTEND (1 cycle): `pattern[round_len] <= lfsr[1:0]`; `round_len++`; `idx<=0`; next state SHOW.
- SHOW: `arrow_valid`=1, `arrow_out`=`pattern[idx]` for exactly `SHOW_CYCLES` cycles, then GAP.
- GAP: `arrow_valid`=0 for `GAP_CYCLES` cycles.
  - If `idx==round_len-1`: `idx<=0`, go to LISTEN.
  - Otherwise: `idx++`, go to SHOW.
- LISTEN: `listening`=1. A press is a rising edge of `clicked_in`, measured against a register of its previous value that is updated every cycle in all states.
  - On a press with `direction_in==pattern[idx]`:
    - If `idx==round_len-1` and `round_len==MAX_LEN`: go to WIN.
    - If `idx==round_len-1` otherwise: go to EXTEND.
    - Else: `idx++`.
  - On a press with a mismatch: go to FAIL.
- A key already held when LISTEN is entered produces no press until it is released and pressed again.
- Presses outside LISTEN are discarded.
- WIN/FAIL: `win`/`fail` stays at 1 until the next accepted `start`.
- Reset (any time, including mid-playback): state IDLE, `arrow_out`=00, `arrow_valid`=0, `round_len`=0, `listening`=0, `win`=0, `fail`=0, `idx`=0, LFSR=`SEED`, previous-click register=0.
- Pattern RAM contents are not reset.

## Timing
- `start` sampled high in IDLE → EXTEND on the next edge → SHOW one cycle later. `arrow_valid` therefore rises on the 2nd edge after `start`.
- Round `n` playback: n·(SHOW_CYCLES+GAP_CYCLES) cycles from SHOW entry to LISTEN entry.
- Press to decision: the state and outputs change on the edge after the `clicked_in` rising edge is sampled (1-cycle latency).
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- Macro: `SIMON_TIMEOUT_EN`.
- Defined: a counter restarts on LISTEN entry and on every accepted press. If it reaches `TIMEOUT_CYCLES` in LISTEN with no press, go to FAIL. A press in the same cycle as the timeout takes priority.
- Undefined: no counter and no timeout. LISTEN waits indefinitely. `TIMEOUT_CYCLES` is unused.

## Structure
- `simon_pkg`:
  - arrow code constants `ARROW_UP`/`RIGHT`/`DOWN`/`LEFT` (00/01/10/11);
  - state enum `simon_state_t`;
  - LFSR tap mask constant.
- Sub-module `simon_lfsr`: 8-bit free-running LFSR with `SEED` parameter, same clock/reset.
- Pattern store: `MAX_LEN`×2-bit register array inside the controller.

## Test plan
All scenarios use MAX_LEN=4, SHOW_CYCLES=4, GAP_CYCLES=2, SEED=8'h01. The bench records `arrow_out` while `arrow_valid`=1 as the expected sequence.
- `start` pulse in IDLE → `round_len`=1 two edges later; `arrow_valid` high for exactly 4 cycles, low for 2; then `listening`=1.
- Replay each recorded round correctly through 4 rounds → `round_len` goes 1,2,3,4. After the 4th correct press, `win`=1 and `listening`=0. `win` holds for more than 100 cycles.
- Round 2, first press correct and second press wrong (recorded code XOR 2'b01) → `fail`=1 one edge later; `round_len` stays 2. A later `start` → `fail`=0 and `round_len`=1.
- `clicked_in` held high from the middle of SHOW through LISTEN entry → no press accepted. Release, then press the correct code → accepted.
- Assert `resetn`=0 mid-SHOW in round 3 → all outputs 0 immediately, with no clock edge needed. After release, the state is IDLE.
- With `SIMON_TIMEOUT_EN` and TIMEOUT_CYCLES=10: no press in LISTEN → `fail`=1 after 10 cycles. A press on cycle 10 → accepted, no fail.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared definitions for the Simon Says round controller: arrow codes,
// controller state encoding and the LFSR feedback tap mask.
package simon_pkg;

    localparam logic [1:0] ARROW_UP    = 2'b00;
    localparam logic [1:0] ARROW_RIGHT = 2'b01;
    localparam logic [1:0] ARROW_DOWN  = 2'b10;
    localparam logic [1:0] ARROW_LEFT  = 2'b11;

    // Taps 8,6,5,4 of an 8-bit Fibonacci LFSR (bits 7,5,4,3).
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXTEND,
        ST_SHOW,
        ST_GAP,
        ST_LISTEN,
        ST_WIN,
        ST_FAIL
    } simon_state_t;

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 8-bit Fibonacci LFSR. Advances every cycle from SEED and
// exposes its two low bits as the next random arrow code.
module simon_lfsr
    import simon_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clock,
    input  logic       resetn,
    output logic [1:0] o_bits
);

    logic [7:0] r_lfsr;
    logic       w_fb;

    assign w_fb   = ^(r_lfsr & LFSR_TAPS);
    assign o_bits = r_lfsr[1:0];

    // Shift in the XOR of the tapped bits every cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
        end
    end

endmodule

// File: rtl/simon_round_ctrl.sv
// Simon Says round controller: grows a random arrow sequence one step per
// round, plays it back, then checks the player's presses against it.
// Optional listen timeout is enabled by defining SIMON_TIMEOUT_EN.
module simon_round_ctrl
    import simon_pkg::*;
#(
    parameter int unsigned MAX_LEN        = 16,
    parameter int unsigned SHOW_CYCLES    = 25_000_000,
    parameter int unsigned GAP_CYCLES     = 12_500_000,
    parameter logic [7:0]  SEED           = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         start,
    input  logic [1:0]                   direction_in,
    input  logic                         clicked_in,
    output logic [1:0]                   arrow_out,
    output logic                         arrow_valid,
    output logic [$clog2(MAX_LEN+1)-1:0] round_len,
    output logic                         listening,
    output logic                         win,
    output logic                         fail
);

    localparam int unsigned RL_W     = $clog2(MAX_LEN + 1);
    localparam int unsigned IDX_W    = $clog2(MAX_LEN);
    localparam int unsigned CNT_MAX0 = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_MAX  = (TIMEOUT_CYCLES > CNT_MAX0) ? TIMEOUT_CYCLES : CNT_MAX0;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    simon_state_t     r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [IDX_W-1:0] r_idx, w_idx_next;
    logic [RL_W-1:0]  r_round_len, w_round_len_next;
    logic             r_win, w_win_next;
    logic             r_fail, w_fail_next;
    logic             r_click_prev;
    logic [1:0]       r_arrow_out;
    logic             r_arrow_valid;
    logic             r_listening;
    logic [1:0]       r_pattern [MAX_LEN];

    logic [1:0]       w_rand;
    logic             w_wr_en;
    logic             w_press;
    logic             w_last;
    logic             w_match;
    logic [1:0]       w_show_code;

    simon_lfsr #(.SEED(SEED)) u_lfsr (
        .clock  (clock),
        .resetn (resetn),
        .o_bits (w_rand)
    );

    assign w_press = clicked_in & ~r_click_prev;
    assign w_last  = (RL_W'(r_idx) == (r_round_len - RL_W'(1)));
    assign w_match = (direction_in == r_pattern[r_idx]);

    // The first arrow of round 1 is being written on the same edge that
    // enters SHOW, so forward the LFSR bits instead of the stale RAM entry.
    assign w_show_code = (r_state == ST_EXTEND && r_round_len == '0) ? w_rand
                                                                       : r_pattern[w_idx_next];

    // Next-state and next-value logic for the round controller.
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_idx_next       = r_idx;
        w_round_len_next = r_round_len;
        w_win_next       = r_win;
        w_fail_next      = r_fail;
        w_wr_en          = 1'b0;
        case (r_state)
            ST_IDLE, ST_WIN, ST_FAIL: begin
                if (start) begin
                    w_state_next     = ST_EXTEND;
                    w_round_len_next = '0;
                    w_win_next       = 1'b0;
                    w_fail_next      = 1'b0;
                    w_idx_next       = '0;
                end
            end
            ST_EXTEND: begin
                w_wr_en          = 1'b1;
                w_round_len_next = r_round_len + RL_W'(1);
                w_idx_next       = '0;
                w_cnt_next       = '0;
                w_state_next     = ST_SHOW;
            end
            ST_SHOW: begin
                if (r_cnt == CNT_W'(SHOW_CYCLES - 1)) begin
                    w_cnt_next   = '0;
                    w_state_next = ST_GAP;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    w_cnt_next = '0;
                    if (w_last) begin
                        w_idx_next   = '0;
                        w_state_next = ST_LISTEN;
                    end else begin
                        w_idx_next   = r_idx + IDX_W'(1);
                        w_state_next = ST_SHOW;
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            ST_LISTEN: begin
                if (w_press) begin
                    w_cnt_next = '0;
                    if (!w_match) begin
                        w_state_next = ST_FAIL;
                        w_fail_next  = 1'b1;
                    end else if (w_last) begin
                        if (r_round_len == RL_W'(MAX_LEN)) begin
                            w_state_next = ST_WIN;
                            w_win_next   = 1'b1;
                        end else begin
                            w_state_next = ST_EXTEND;
                        end
                    end else begin
                        w_idx_next = r_idx + IDX_W'(1);
                    end
                end
`ifdef SIMON_TIMEOUT_EN
                else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_state_next = ST_FAIL;
                    w_fail_next  = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
`endif
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_round_len   <= '0;
            r_win         <= 1'b0;
            r_fail        <= 1'b0;
            r_click_prev  <= 1'b0;
            r_arrow_out   <= ARROW_UP;
            r_arrow_valid <= 1'b0;
            r_listening   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_idx         <= w_idx_next;
            r_round_len   <= w_round_len_next;
            r_win         <= w_win_next;
            r_fail        <= w_fail_next;
            r_click_prev  <= clicked_in;
            r_arrow_valid <= (w_state_next == ST_SHOW);
            r_arrow_out   <= (w_state_next == ST_SHOW) ? w_show_code : ARROW_UP;
            r_listening   <= (w_state_next == ST_LISTEN);
        end
    end

    // Pattern store; contents survive reset and are overwritten as rounds grow.
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_pattern[r_round_len[IDX_W-1:0]] <= w_rand;
        end
    end

    assign arrow_out   = r_arrow_out;
    assign arrow_valid = r_arrow_valid;
    assign round_len   = r_round_len;
    assign listening   = r_listening;
    assign win         = r_win;
    assign fail        = r_fail;

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Scoreboard bench for simon_round_ctrl with small timing parameters.
module tb_simon_round_ctrl;

    localparam int MAX_LEN = 4;
    localparam int SHOW    = 4;
    localparam int GAP     = 2;
    localparam int TMO     = 10;
    localparam int PB      = SHOW + GAP;

    localparam int K_NONE = 0;
    localparam int K_PLAY = 1;
    localparam int K_WIN  = 2;
    localparam int K_FAIL = 3;

    logic       clock = 1'b0;
    logic       resetn = 1'b1;
    logic       start = 1'b0;
    logic [1:0] direction_in = 2'b00;
    logic       clicked_in = 1'b0;
    logic [1:0] arrow_out;
    logic       arrow_valid;
    logic [2:0] round_len;
    logic       listening;
    logic       win;
    logic       fail;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int kind;
        int len;
        int cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] model_seq[$];

    simon_round_ctrl #(
        .MAX_LEN        (MAX_LEN),
        .SHOW_CYCLES    (SHOW),
        .GAP_CYCLES     (GAP),
        .SEED           (8'h01),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .start        (start),
        .direction_in (direction_in),
        .clicked_in   (clicked_in),
        .arrow_out    (arrow_out),
        .arrow_valid  (arrow_valid),
        .round_len    (round_len),
        .listening    (listening),
        .win          (win),
        .fail         (fail)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_listen(output bit ok);
        int k = 0;
        while (!listening && k < 200) begin
            tick(1);
            k++;
        end
        ok = listening;
        if (!ok) chk("listen_wait_expired", 0, 1);
    endtask

    task automatic wait_valid(output bit ok);
        int k = 0;
        while (!arrow_valid && k < 200) begin
            tick(1);
            k++;
        end
        ok = arrow_valid;
        if (!ok) chk("show_wait_expired", 0, 1);
    endtask

    task automatic do_start();
        model_seq.delete();
        start = 1'b1;
        exp_q.push_back(exp_t'{K_PLAY, 1, cyc + 2 + PB});
        tick(1);
        start = 1'b0;
    endtask

    // Press for one cycle, then release. Expectation is queued before the press.
    task automatic press(input logic [1:0] code, input int kind, input int len);
        direction_in = code;
        clicked_in   = 1'b1;
        if (kind == K_WIN || kind == K_FAIL) exp_q.push_back(exp_t'{kind, len, cyc + 1});
        else if (kind == K_PLAY)             exp_q.push_back(exp_t'{K_PLAY, len, cyc + 2 + PB * len});
        tick(1);
        clicked_in = 1'b0;
        tick(1);
    endtask

    // Replay a whole round of length n with random pauses between presses.
    task automatic play_round(input int n);
        bit ok;
        wait_listen(ok);
        if (!ok) return;
        if (model_seq.size() < n) begin
            chk("recorded_seq_size", model_seq.size(), n);
            return;
        end
        for (int i = 0; i < n; i++) begin
            tick($urandom_range(0, 3));
            if (i < n - 1)           press(model_seq[i], K_NONE, 0);
            else if (n == MAX_LEN)   press(model_seq[i], K_WIN, n);
            else                     press(model_seq[i], K_PLAY, n + 1);
        end
    endtask

    // Monitor: records playback, checks show/gap timing and pops expectations.
    logic       prev_v = 1'b0, prev_l = 1'b0, prev_w = 1'b0, prev_f = 1'b0;
    int         hi_run = 0, lo_run = 0, shown_n = 0;
    logic [1:0] cur_code = 2'b00;
    exp_t       e;

    always @(negedge clock) begin
        if (!resetn) begin
            prev_v = 1'b0; prev_l = 1'b0; prev_w = 1'b0; prev_f = 1'b0;
            hi_run = 0; lo_run = 0; shown_n = 0;
        end else begin
            if (listening && !prev_l) begin
                chk("final_gap_len", lo_run, GAP);
                if (exp_q.size() == 0) chk("unexpected_listen", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("listen_kind", K_PLAY, e.kind);
                    chk("listen_round_len", round_len, e.len);
                    chk("listen_cycle", cyc, e.cyc);
                    chk("arrows_shown", shown_n, e.len);
                    chk("recorded_len", model_seq.size(), e.len);
                end
                shown_n = 0;
            end
            if (arrow_valid) begin
                if (!prev_v) begin
                    if (shown_n > 0) chk("gap_len", lo_run, GAP);
                    hi_run   = 0;
                    cur_code = arrow_out;
                end else if (arrow_out != cur_code) begin
                    chk("arrow_stable", arrow_out, cur_code);
                end
                hi_run++;
            end else begin
                if (prev_v) begin
                    chk("show_len", hi_run, SHOW);
                    if (shown_n < model_seq.size()) chk("replayed_code", cur_code, model_seq[shown_n]);
                    else                            model_seq.push_back(cur_code);
                    shown_n++;
                    lo_run = 0;
                end
                lo_run++;
            end
            if (win && !prev_w) begin
                if (exp_q.size() == 0) chk("unexpected_win", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("win_kind", K_WIN, e.kind);
                    chk("win_round_len", round_len, e.len);
                    chk("win_cycle", cyc, e.cyc);
                end
            end
            if (fail && !prev_f) begin
                if (exp_q.size() == 0) chk("unexpected_fail", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("fail_kind", K_FAIL, e.kind);
                    chk("fail_round_len", round_len, e.len);
                    chk("fail_cycle", cyc, e.cyc);
                end
            end
            prev_v = arrow_valid;
            prev_l = listening;
            prev_w = win;
            prev_f = fail;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run still active at %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        bit ok;
        int wins;
        int e_cyc;
        logic [1:0] wrong;

        // Reset values
        #1 resetn = 1'b0;
        #2;
        chk("rst_arrow_out", arrow_out, 0);
        chk("rst_arrow_valid", arrow_valid, 0);
        chk("rst_round_len", round_len, 0);
        chk("rst_listening", listening, 0);
        chk("rst_win", win, 0);
        chk("rst_fail", fail, 0);
        tick(3);
        resetn = 1'b1;
        tick($urandom_range(1, 5));

        // Full game to a win
        do_start();
        tick(1);
        chk("start_round_len", round_len, 1);
        chk("start_arrow_valid", arrow_valid, 1);
        for (int r = 1; r <= MAX_LEN; r++) play_round(r);
        chk("win_flag", win, 1);
        chk("win_listening", listening, 0);
        wins = 0;
        for (int i = 0; i < 120; i++) begin
            tick(1);
            if (win) wins++;
        end
        chk("win_hold_cycles", wins, 120);

        // Wrong second press in round 2
        do_start();
        play_round(1);
        wait_listen(ok);
        if (ok && model_seq.size() >= 2) begin
            tick($urandom_range(0, 3));
            press(model_seq[0], K_NONE, 0);
            wrong = model_seq[1] ^ 2'b01;
            press(wrong, K_FAIL, 2);
            chk("fail_flag", fail, 1);
            chk("fail_round_len_hold", round_len, 2);
            chk("fail_listening", listening, 0);
        end else begin
            chk("round2_ready", 0, 1);
        end
        do_start();
        tick(1);
        chk("restart_fail_clear", fail, 0);
        chk("restart_round_len", round_len, 1);

        // Key held from mid-show through listen entry
        wait_valid(ok);
        tick(2);
        direction_in = 2'($urandom);
        clicked_in   = 1'b1;
        wait_listen(ok);
        tick(3);
        chk("held_still_listening", listening, 1);
        chk("held_no_fail", fail, 0);
        chk("held_round_len", round_len, 1);
        clicked_in = 1'b0;
        tick(1);
        if (model_seq.size() >= 1) press(model_seq[0], K_PLAY, 2);
        else chk("held_seq_size", model_seq.size(), 1);
        play_round(2);

        // Reset in the middle of round 3 playback
        wait_valid(ok);
        tick(1);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_arrow_out", arrow_out, 0);
        chk("midrst_arrow_valid", arrow_valid, 0);
        chk("midrst_round_len", round_len, 0);
        chk("midrst_listening", listening, 0);
        chk("midrst_win", win, 0);
        chk("midrst_fail", fail, 0);
        exp_q.delete();
        model_seq.delete();
        tick(2);
        resetn = 1'b1;
        tick(10);
        chk("post_rst_idle_valid", arrow_valid, 0);
        chk("post_rst_idle_len", round_len, 0);
        chk("post_rst_idle_listen", listening, 0);
        do_start();
        play_round(1);
        wait_listen(ok);

`ifdef SIMON_TIMEOUT_EN
        // Timeout with no press, then a press on the last allowed cycle
        e_cyc = cyc;
        exp_q.push_back(exp_t'{K_FAIL, 2, e_cyc + TMO});
        tick(TMO + 2);
        chk("timeout_fail", fail, 1);
        do_start();
        wait_listen(ok);
        tick(TMO - 1);
        if (model_seq.size() >= 1) press(model_seq[0], K_PLAY, 2);
        chk("late_press_no_fail", fail, 0);
        wait_listen(ok);
        e_cyc = cyc;
        exp_q.push_back(exp_t'{K_FAIL, 2, e_cyc + TMO});
        tick(TMO + 2);
        chk("timeout_fail_r2", fail, 1);
`else
        e_cyc = 0;
        tick(3 + e_cyc);
`endif

        tick(5);
        chk("pending_expectations", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
